// File: rtl/axi_mem_pkg.sv
// Shared constants and state types for the AXI4-Lite slave memory.
// Holds the response codes and the write/read channel FSM states.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axi_mem_array.sv
// Byte-enabled word array with one synchronous write port and a combinational
// read port. The contents are never reset.
module axi_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_WIDTH-1:0]    ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Callers only enable writes for in-range indices, so the upper index bits
    // carry no information here.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[widx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx[AW-1:0]];

    if (AW < IDX_WIDTH) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^{widx[IDX_WIDTH-1:AW], ridx[IDX_WIDTH-1:AW]};
    end

endmodule

// File: rtl/axi_lite_mem.sv
// AXI4-Lite slave memory: independent write (AW/W/B) and read (AR/R) FSMs
// in front of a byte-enabled word array; out-of-range words answer SLVERR.
module axi_lite_mem
    import axi_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 2 ** (ADDR_WIDTH - 2)
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF        = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - OFF;

    function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
        return {1'b0, idx} < (IDX_WIDTH + 1)'(DEPTH);
    endfunction

    wstate_t wstate;
    rstate_t rstate;

    logic                  aw_done;
    logic                  w_done;
    logic [IDX_WIDTH-1:0]  aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [IDX_WIDTH-1:0]  aw_idx_in;
    logic [IDX_WIDTH-1:0]  ar_idx;
    logic [IDX_WIDTH-1:0]  c_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_WIDTH-1:0] c_strb;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign aw_idx_in = s0_axi_awaddr[ADDR_WIDTH-1:OFF];
    assign ar_idx    = s0_axi_araddr[ADDR_WIDTH-1:OFF];

    assign aw_hs  = s0_axi_awvalid && s0_axi_awready;
    assign w_hs   = s0_axi_wvalid && s0_axi_wready;
    assign ar_hs  = s0_axi_arvalid && s0_axi_arready;

    // The commit edge may coincide with either handshake, so take whichever
    // half is still on the bus rather than the captured copy.
    assign commit = (wstate == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    assign c_idx  = aw_done ? aw_idx_q : aw_idx_in;
    assign c_data = w_done ? wdata_q : s0_axi_wdata;
    assign c_strb = w_done ? wstrb_q : s0_axi_wstrb;
    assign mem_we = commit && in_range(c_idx);

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_array (
        .clk   (s0_axi_aclk),
        .we    (mem_we),
        .widx  (c_idx),
        .wdata (c_data),
        .wstrb (c_strb),
        .ridx  (ar_idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
            wstate         <= W_IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            aw_idx_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            s0_axi_bvalid  <= 1'b0;
            s0_axi_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_done  <= 1'b1;
                        aw_idx_q <= aw_idx_in;
                    end
                    if (w_hs) begin
                        w_done  <= 1'b1;
                        wdata_q <= s0_axi_wdata;
                        wstrb_q <= s0_axi_wstrb;
                    end
                    if (commit) begin
                        wstate         <= W_RESP;
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        s0_axi_awready <= 1'b0;
                        s0_axi_wready  <= 1'b0;
                        s0_axi_bvalid  <= 1'b1;
                        s0_axi_bresp   <= in_range(c_idx) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        s0_axi_awready <= !(aw_done || aw_hs);
                        s0_axi_wready  <= !(w_done || w_hs);
                    end
                end
                W_RESP: begin
                    if (s0_axi_bready) begin
                        wstate         <= W_IDLE;
                        s0_axi_bvalid  <= 1'b0;
                        s0_axi_awready <= 1'b1;
                        s0_axi_wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
            rstate         <= R_IDLE;
            s0_axi_arready <= 1'b0;
            s0_axi_rvalid  <= 1'b0;
            s0_axi_rdata   <= '0;
            s0_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate         <= R_DATA;
                        s0_axi_arready <= 1'b0;
                        s0_axi_rvalid  <= 1'b1;
                        s0_axi_rdata   <= in_range(ar_idx) ? mem_rdata : '0;
                        s0_axi_rresp   <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        s0_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s0_axi_rready) begin
                        rstate         <= R_IDLE;
                        s0_axi_rvalid  <= 1'b0;
                        s0_axi_arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    if (OFF > 0) begin : g_off_bits
        logic unused_off;
        assign unused_off = ^{s0_axi_awaddr[OFF-1:0], s0_axi_araddr[OFF-1:0]};
    end

endmodule
